// File: rtl/n64_ctrl_sniffer_multi_pkg.sv
// Shared joybus definitions for the multi-port controller sniffer.
// Holds the command codes, frame lengths, payload widths and the receiver
// FSM state encoding used by the top and by the per-channel receiver.
package n64_ctrl_sniffer_multi_pkg;

  localparam logic [7:0] CMD_POLL  = 8'h01;
  localparam logic [7:0] CMD_INFO  = 8'h00;
  localparam logic [7:0] CMD_RESET = 8'hFF;

  localparam int unsigned CMD_BITS  = 8;
  localparam int unsigned POLL_BITS = 32;
  localparam int unsigned INFO_BITS = 24;

  localparam int unsigned POLL_W  = 32;
  localparam int unsigned INFO_W  = 24;
  localparam int unsigned OVR_W   = 8;
  localparam int unsigned COMBO_W = 16;
  localparam int unsigned BITC_W  = 6;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CMD  = 2'd1,
    ST_POLL = 2'd2,
    ST_INFO = 2'd3
  } rx_state_e;

  // Info and reset commands both answer with the 24-bit info word.
  function automatic logic is_info_cmd(input logic [7:0] cmd);
    return (cmd == CMD_INFO) || (cmd == CMD_RESET);
  endfunction

endpackage

// File: rtl/n64_ctrl_sniffer_multi_if.sv
// Bundle of the sniffer's line, handshake and result signals.
//   ctrl_i      raw joybus lines, one per port (asynchronous)
//   ack_tgl_i   per-channel acknowledge toggle (clk domain)
//   igr_en_i    in-game-reset enable (clk domain)
//   igr_combo_i button pattern compared against poll word [15:0]
//   data_o      last poll word per channel, channel n at [32n+31:32n]
//   info_o      last info word per channel, channel n at [24n+23:24n]
//   valid_o     poll data pending per channel
//   overrun_o   saturating overwrite count per channel, 8 bits each
//   igr_req_o   one-cycle in-game-reset request per channel
// master: the side that drives the lines and consumes results; slave: the sniffer.
interface n64_ctrl_sniffer_multi_if #(
  parameter int unsigned NUM_CH = 4
);
  import n64_ctrl_sniffer_multi_pkg::*;

  logic [NUM_CH-1:0]        ctrl_i;
  logic [NUM_CH-1:0]        ack_tgl_i;
  logic                     igr_en_i;
  logic [COMBO_W-1:0]       igr_combo_i;
  logic [POLL_W*NUM_CH-1:0] data_o;
  logic [INFO_W*NUM_CH-1:0] info_o;
  logic [NUM_CH-1:0]        valid_o;
  logic [OVR_W*NUM_CH-1:0]  overrun_o;
  logic [NUM_CH-1:0]        igr_req_o;

  modport master (
    output ctrl_i, ack_tgl_i, igr_en_i, igr_combo_i,
    input  data_o, info_o, valid_o, overrun_o, igr_req_o
  );

  modport slave (
    input  ctrl_i, ack_tgl_i, igr_en_i, igr_combo_i,
    output data_o, info_o, valid_o, overrun_o, igr_req_o
  );

endinterface

// File: rtl/n64_ctrl_sniffer_multi_rx_ch.sv
// One joybus channel receiver: synchroniser, edge history, bit-timing
// counter, pulse-width bit decode and command/response FSM.
//   clk, reset    controller clock, async active-high reset
//   ctrl_i        raw joybus line
//   poll_stb_o    one-cycle strobe, poll_word_o holds a new poll response
//   poll_word_o   captured 32-bit poll response (first bit in bit 0)
//   info_stb_o    one-cycle strobe, info_word_o holds a new info response
//   info_word_o   captured 24-bit info response (first bit in bit 0)
module n64_ctrl_sniffer_multi_rx_ch
  import n64_ctrl_sniffer_multi_pkg::*;
#(
  parameter int unsigned CNT_W    = 8,
  parameter int unsigned MIN_IDLE = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ctrl_i,
  output logic              poll_stb_o,
  output logic [POLL_W-1:0] poll_word_o,
  output logic              info_stb_o,
  output logic [INFO_W-1:0] info_word_o
);

  logic [1:0]        sync_q;
  logic              hist_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [CNT_W-1:0]  low_cnt_q;
  rx_state_e         state_q;
  logic [POLL_W-1:0] sh_q;
  logic [BITC_W-1:0] bit_cnt_q;
  logic              first_q;

  logic              neg_c;
  logic              pos_c;
  logic              sat_c;
  logic              bit_c;
  logic [7:0]        cmd_c;
  logic [POLL_W-1:0] poll_c;
  logic [INFO_W-1:0] info_c;

  // Edges seen between the synchroniser output and the history flop.
  assign neg_c  = hist_q & ~sync_q[1];
  assign pos_c  = ~hist_q & sync_q[1];
  assign sat_c  = &cnt_q;
  // Short low / long high is a 1; equal widths decode as 0.
  assign bit_c  = (low_cnt_q < cnt_q);
  assign cmd_c  = {sh_q[6:0], bit_c};
  assign poll_c = {bit_c, sh_q[POLL_W-1:1]};
  assign info_c = {bit_c, sh_q[INFO_W-1:1]};

  // Line tracking, timing and frame FSM.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q      <= '1;
      hist_q      <= 1'b1;
      cnt_q       <= '0;
      low_cnt_q   <= '0;
      state_q     <= ST_IDLE;
      sh_q        <= '0;
      bit_cnt_q   <= '0;
      first_q     <= 1'b0;
      poll_stb_o  <= 1'b0;
      poll_word_o <= '0;
      info_stb_o  <= 1'b0;
      info_word_o <= '0;
    end else begin
      poll_stb_o <= 1'b0;
      info_stb_o <= 1'b0;
      sync_q     <= {sync_q[0], ctrl_i};
      hist_q     <= sync_q[1];

      if (neg_c || pos_c) begin
        cnt_q <= '0;
      end else if (!sat_c) begin
        cnt_q <= cnt_q + CNT_W'(1);
      end

      if (pos_c) begin
        low_cnt_q <= cnt_q;
      end

      // The first negedge of every frame only opens bit 0; each later
      // negedge closes the previous bit, so decoding lags by one edge.
      case (state_q)
        ST_IDLE: begin
          if (neg_c && (cnt_q >= CNT_W'(MIN_IDLE))) begin
            state_q   <= ST_CMD;
            bit_cnt_q <= '0;
          end
        end
        ST_CMD: begin
          if (sat_c) begin
            state_q <= ST_IDLE;
          end else if (neg_c) begin
            sh_q <= {sh_q[POLL_W-2:0], bit_c};
            if (bit_cnt_q == BITC_W'(CMD_BITS - 1)) begin
              bit_cnt_q <= '0;
              first_q   <= 1'b1;
              if (cmd_c == CMD_POLL) begin
                state_q <= ST_POLL;
              end else if (is_info_cmd(cmd_c)) begin
                state_q <= ST_INFO;
              end else begin
                state_q <= ST_IDLE;
              end
            end else begin
              bit_cnt_q <= bit_cnt_q + BITC_W'(1);
            end
          end
        end
        ST_POLL: begin
          if (sat_c) begin
            state_q <= ST_IDLE;
          end else if (neg_c) begin
            if (first_q) begin
              first_q <= 1'b0;
            end else begin
              sh_q <= poll_c;
              if (bit_cnt_q == BITC_W'(POLL_BITS - 1)) begin
                poll_word_o <= poll_c;
                poll_stb_o  <= 1'b1;
                state_q     <= ST_IDLE;
              end else begin
                bit_cnt_q <= bit_cnt_q + BITC_W'(1);
              end
            end
          end
        end
        ST_INFO: begin
          if (sat_c) begin
            state_q <= ST_IDLE;
          end else if (neg_c) begin
            if (first_q) begin
              first_q <= 1'b0;
            end else begin
              sh_q[INFO_W-1:0] <= info_c;
              if (bit_cnt_q == BITC_W'(INFO_BITS - 1)) begin
                info_word_o <= info_c;
                info_stb_o  <= 1'b1;
                state_q     <= ST_IDLE;
              end else begin
                bit_cnt_q <= bit_cnt_q + BITC_W'(1);
              end
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/n64_ctrl_sniffer_multi.sv
// Multi-port N64 controller sniffer. Decodes NUM_CH joybus lines in
// parallel and presents poll/info responses with a per-channel
// valid / toggle-acknowledge handshake and overrun counter.
//   clk    controller sampling clock
//   reset  asynchronous reset, active high
//   bus    n64_ctrl_sniffer_multi_if.slave: lines, ack toggles, IGR
//          controls in; data/info/valid/overrun/igr_req out
// Optional feature: define N64_CTRL_IGR_EN to build the in-game-reset
// combo detector; otherwise igr_req_o is constant 0.
module n64_ctrl_sniffer_multi
  import n64_ctrl_sniffer_multi_pkg::*;
#(
  parameter int unsigned NUM_CH   = 4,
  parameter int unsigned CNT_W    = 8,
  parameter int unsigned MIN_IDLE = 32'hFF
) (
  input  logic                           clk,
  input  logic                           reset,
  n64_ctrl_sniffer_multi_if.slave        bus
);

  logic              poll_stb  [NUM_CH];
  logic [POLL_W-1:0] poll_word [NUM_CH];
  logic              info_stb  [NUM_CH];
  logic [INFO_W-1:0] info_word [NUM_CH];

  logic [POLL_W-1:0] data_q    [NUM_CH];
  logic [INFO_W-1:0] info_q    [NUM_CH];
  logic [OVR_W-1:0]  ovr_q     [NUM_CH];
  logic [NUM_CH-1:0] valid_q;
  logic [NUM_CH-1:0] ack_q;
  logic [NUM_CH-1:0] ack_c;

  for (genvar n = 0; n < NUM_CH; n++) begin : g_ch
    n64_ctrl_sniffer_multi_rx_ch #(
      .CNT_W    (CNT_W),
      .MIN_IDLE (MIN_IDLE)
    ) u_rx (
      .clk         (clk),
      .reset       (reset),
      .ctrl_i      (bus.ctrl_i[n]),
      .poll_stb_o  (poll_stb[n]),
      .poll_word_o (poll_word[n]),
      .info_stb_o  (info_stb[n]),
      .info_word_o (info_word[n])
    );
  end

  assign ack_c = bus.ack_tgl_i ^ ack_q;

  // Handshake: a commit beats a same-cycle ack and is then not an overrun.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q <= '0;
      ack_q   <= '0;
      for (int n = 0; n < NUM_CH; n++) begin
        data_q[n] <= '0;
        info_q[n] <= '0;
        ovr_q[n]  <= '0;
      end
    end else begin
      ack_q <= bus.ack_tgl_i;
      for (int n = 0; n < NUM_CH; n++) begin
        if (info_stb[n]) begin
          info_q[n] <= info_word[n];
        end
        if (poll_stb[n]) begin
          data_q[n]  <= poll_word[n];
          valid_q[n] <= 1'b1;
          if (valid_q[n] && !ack_c[n] && (ovr_q[n] != '1)) begin
            ovr_q[n] <= ovr_q[n] + OVR_W'(1);
          end
        end else if (ack_c[n]) begin
          valid_q[n] <= 1'b0;
        end
      end
    end
  end

  // Pack per-channel registers onto the flat output buses.
  always_comb begin
    bus.data_o    = '0;
    bus.info_o    = '0;
    bus.overrun_o = '0;
    for (int n = 0; n < NUM_CH; n++) begin
      bus.data_o[POLL_W*n +: POLL_W]  = data_q[n];
      bus.info_o[INFO_W*n +: INFO_W]  = info_q[n];
      bus.overrun_o[OVR_W*n +: OVR_W] = ovr_q[n];
    end
  end

  assign bus.valid_o = valid_q;

`ifdef N64_CTRL_IGR_EN
  logic [NUM_CH-1:0] igr_q;
  logic [NUM_CH-1:0] prev_match_q;
  logic [NUM_CH-1:0] match_c;

  always_comb begin
    match_c = '0;
    for (int n = 0; n < NUM_CH; n++) begin
      match_c[n] = (poll_word[n][COMBO_W-1:0] == bus.igr_combo_i);
    end
  end

  // Pulse only on the first matching word, so a held combo fires once.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      igr_q        <= '0;
      prev_match_q <= '0;
    end else begin
      igr_q <= '0;
      for (int n = 0; n < NUM_CH; n++) begin
        if (poll_stb[n]) begin
          prev_match_q[n] <= match_c[n];
          igr_q[n]        <= bus.igr_en_i & match_c[n] & ~prev_match_q[n];
        end
      end
    end
  end

  assign bus.igr_req_o = igr_q;
`else
  logic unused_igr;
  assign unused_igr    = ^{bus.igr_en_i, bus.igr_combo_i};
  assign bus.igr_req_o = '0;
`endif

endmodule
